// File: rtl/inst_pkg.sv
// Shared constants and FSM state type for the instruction feed queue.
package inst_pkg;

    localparam logic [6:0]  NOP_OPCODE = 7'b1111111;
    localparam logic [31:0] NOP_WORD   = 32'h0000007F;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_fifo_ram.sv
// DEPTH x 32 instruction storage: one write port, one async read port.
module inst_fifo_ram #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_feed_queue.sv
// Instruction feed FIFO between a symbolic source and core fetch,
// with NOP filtering, flush, and a bounded instruction budget.
module inst_feed_queue #(
    parameter int DEPTH     = 4,
    parameter int MAX_INSTS = 16
) (
    input  logic                         clk,
    input  logic                         reset_x,
    input  logic [31:0]                  in_inst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [31:0]                  out_inst,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(MAX_INSTS+1)-1:0] accepted,
    output logic                         done
);

    import inst_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(MAX_INSTS+1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [NW-1:0] acc_q;
    logic [31:0]   rd_data;
    logic          is_nop;
    logic          enq;
    logic          deq;

    // in_ready is gated by reset_x so it drops without waiting for a clock
    assign in_ready  = reset_x && (state_q == RUN)
                    && (count_q < CW'(DEPTH)) && !flush;
    assign is_nop    = (in_inst[6:0] == NOP_OPCODE);
    assign enq       = in_valid && in_ready && !is_nop
                    && (acc_q < NW'(MAX_INSTS));
    assign out_valid = (count_q != '0);
    assign deq       = out_valid && out_ready && !flush;
    assign out_inst  = out_valid ? rd_data : NOP_WORD;
    assign count     = count_q;
    assign accepted  = acc_q;
    assign done      = (state_q == DONE);

    inst_fifo_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (enq),
        .waddr(tail_q),
        .wdata(in_inst),
        .raddr(head_q),
        .rdata(rd_data)
    );

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            flush:        count_d = '0;
            enq && !deq:  count_d = count_q + 1'b1;
            !enq && deq:  count_d = count_q - 1'b1;
            default:      count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (enq && (acc_q == NW'(MAX_INSTS-1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (enq) tail_q <= tail_q + 1'b1;
                if (deq) head_q <= head_q + 1'b1;
            end
            if (enq) acc_q <= acc_q + 1'b1;
        end
    end

endmodule

// File: doc/inst_feed_queue.md
INST_FEED_QUEUE -- requirements
Module: inst_feed_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_INSTS, default 16, maximum non-NOP instructions accepted per run.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_x  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_inst  input  32  candidate instruction word from the constrained symbolic source.
REQ-006 SHALL have port in_valid  input  1  in_inst is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  queue accepts in_inst this cycle.
REQ-008 SHALL have port out_inst  output  32  head instruction presented to core fetch.
REQ-009 SHALL have port out_valid  output  1  out_inst valid (core valid_instruction).
REQ-010 SHALL have port out_ready  input  1  core consumes head this cycle (low = core stall).
REQ-011 SHALL have port flush  input  1  branch-mispredict flush from core.
REQ-012 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have port accepted  output  clog2(MAX_INSTS+1)  non-NOP instructions accepted since reset.
REQ-014 SHALL have port done  output  1  run budget exhausted and queue drained.

Function
REQ-015 SHALL implement a circular FIFO: head/tail pointers wrap modulo DEPTH; out_inst = entry at head; out_valid = (count != 0).
REQ-016 SHALL drive in_ready = (state == RUN) && (count < DEPTH) && !flush; no enqueue while full, even if out_ready is high that cycle.
REQ-017 SHALL complete an input handshake when in_valid && in_ready.
REQ-018 SHALL treat a handshaken word with in_inst[6:0] == 7'b1111111 as NOP: consumed, not enqueued, accepted unchanged.
REQ-019 SHALL enqueue a handshaken non-NOP word at tail and increment accepted, with zero-bubble latency: the word is visible on out_inst the next cycle if the queue was empty.
REQ-020 SHALL dequeue head when out_valid && out_ready.
REQ-021 SHALL support simultaneous enqueue and dequeue in one cycle with count unchanged.
REQ-022 SHALL hold out_inst and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, on flush, clear count and reset both pointers to 0 next cycle; flush overrides any same-cycle enqueue or dequeue; accepted is not decremented.
REQ-024 SHALL implement states RUN, DRAIN, DONE.
REQ-025 RUN -> DRAIN when an enqueue makes accepted equal MAX_INSTS.
REQ-026 DRAIN -> DONE when count becomes 0, either by the last dequeue or by flush.
REQ-027 DONE SHALL be terminal until reset; done = (state == DONE), registered.
REQ-028 accepted SHALL saturate at MAX_INSTS and never wrap.
REQ-029 SHALL produce no X on outputs after reset regardless of unused FIFO storage contents; out_inst SHALL be 32'h0000007F whenever count == 0.

Reset
REQ-030 On reset_x low, asynchronously: state = RUN, count = 0, head = tail = 0, accepted = 0, done = 0, out_valid = 0, in_ready = 0.
REQ-031 Reset asserted mid-operation SHALL discard queued entries; first enqueue is permitted on the first rising edge after reset_x rises.
REQ-032 FIFO storage need not be reset.

Structure
REQ-033 Shared package inst_pkg SHALL hold the NOP opcode constant 7'b1111111 and the RUN/DRAIN/DONE state typedef.
REQ-034 Storage SHALL be a sub-module inst_fifo_ram (DEPTH x 32, one write port, one async read port); control and FSM stay in inst_feed_queue.

Verification
REQ-035 Reset, then 0x003100B3 (ADD x1,x2,x3) with in_valid=1, out_ready=1 -> out_valid=1, out_inst=0x003100B3 next cycle; accepted=1.
REQ-036 Present 0x0000007F, then 0x00A00093 (ADDI x1,x0,10) -> only 0x00A00093 appears at out_inst; accepted=1.
REQ-037 out_ready=0, push 5 distinct words into DEPTH=4 -> in_ready=0 after the 4th, count=4; release out_ready -> words exit in order, count reaches 0.
REQ-038 count=3 and flush=1 with in_valid=1 the same cycle -> next cycle count=0, out_valid=0, accepted unchanged.
REQ-039 MAX_INSTS=2: push 2 non-NOP words -> in_ready=0 (DRAIN); drain both -> done=1 one cycle after the last dequeue; done stays high.
REQ-040 reset_x pulsed low with count=2 mid-cycle -> outputs reset immediately, without a clock edge.
